// File: rtl/sap_bus_error_responder.sv
// sap_bus_error_responder
//   OBI slave that terminates transactions decoding to no valid region.
//   Every granted access is answered after RESP_LAT cycles with err_o set
//   and rdata_o = ERR_PATTERN. A saturating error counter and a sticky
//   interrupt report the activity to the safe-CPU supervisor.
//   Optional build macro SAP_BUS_ERR_LOG_EN: capture address/we of the most
//   recent errored access on last_addr_o/last_we_o. Without it those ports
//   read 0 and no capture flops exist.
module sap_bus_error_responder #(
  parameter int unsigned RESP_LAT    = 1,
  parameter logic [31:0] ERR_PATTERN = 32'hBADACCE5,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  input  logic              clear_i,
  output logic [CNT_W-1:0]  err_count_o,
  output logic              err_irq_o,
  output logic [31:0]       last_addr_o,
  output logic              last_we_o
);

  localparam int unsigned LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [LAT_W-1:0]   latCnt_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic [CNT_W-1:0]   count_q;
  logic               irq_q;
  logic               grant;
  logic               unusedInputs;

  // Only one transaction may be outstanding, so grants happen only in IDLE.
  assign grant = req_i && (state_q == IDLE);

  assign gnt_o       = grant;
  assign rvalid_o    = rvalid_q;
  assign err_o       = rvalid_q;
  assign rdata_o     = rdata_q;
  assign err_count_o = count_q;
  assign err_irq_o   = irq_q;

  // Transaction FSM: grant in IDLE, count down latency in WAIT, one-cycle response in RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      latCnt_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            latCnt_q <= LAT_W'(RESP_LAT - 1);
            if (RESP_LAT == 1) begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              rdata_q  <= ERR_PATTERN;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          latCnt_q <= latCnt_q - LAT_W'(1);
          if (latCnt_q == LAT_W'(1)) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= ERR_PATTERN;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Saturating error counter; a clear coinciding with a grant leaves a count of one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= grant ? CNT_W'(1) : '0;
    end else if (grant && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Sticky interrupt set by a response; a simultaneous clear loses to the set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else if (state_q == RESP) begin
      irq_q <= 1'b1;
    end else if (clear_i) begin
      irq_q <= 1'b0;
    end
  end

`ifdef SAP_BUS_ERR_LOG_EN
  logic [31:0] lastAddr_q;
  logic        lastWe_q;

  // Capture the offending access on each grant; clear_i deliberately leaves it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lastAddr_q <= '0;
      lastWe_q   <= 1'b0;
    end else if (grant) begin
      lastAddr_q <= addr_i;
      lastWe_q   <= we_i;
    end
  end

  assign last_addr_o  = lastAddr_q;
  assign last_we_o    = lastWe_q;
  assign unusedInputs = ^{be_i, wdata_i};
`else
  assign last_addr_o  = '0;
  assign last_we_o    = 1'b0;
  assign unusedInputs = ^{be_i, wdata_i, addr_i, we_i};
`endif

endmodule

// File: tb/tb_sap_bus_error_responder.sv
// tb_sap_bus_error_responder
//   Two responder instances (RESP_LAT=1/CNT_W=4 and RESP_LAT=3/CNT_W=16)
//   share one input stream. A cycle-indexed reference model predicts grant
//   timing, response cycle, counter, interrupt and logged access.
module tb_sap_bus_error_responder;

  localparam logic [31:0] PAT = 32'hBADACCE5;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        clear = 1'b0;

  logic        gntW[2];
  logic        rvalidW[2];
  logic        errW[2];
  logic        irqW[2];
  logic        lastWeW[2];
  logic [31:0] rdataW[2];
  logic [31:0] lastAddrW[2];
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  int errors = 0;
  int checks = 0;

  // Reference model state, one slot per instance
  int          lat[2] = '{LAT0, LAT1};
  longint      cntMax[2] = '{15, 65535};
  longint      cyc = 0;
  longint      nextFree[2] = '{0, 0};
  longint      respAt[2] = '{-1, -1};
  longint      mCount[2] = '{0, 0};
  bit          mIrq[2] = '{0, 0};
  logic [31:0] mAddr[2] = '{32'h0, 32'h0};
  bit          mWe[2] = '{0, 0};

  always #5 clk = ~clk;

  sap_bus_error_responder #(.RESP_LAT(LAT0), .ERR_PATTERN(PAT), .CNT_W(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gntW[0]), .rvalid_o(rvalidW[0]), .rdata_o(rdataW[0]),
    .err_o(errW[0]), .clear_i(clear), .err_count_o(cnt0), .err_irq_o(irqW[0]),
    .last_addr_o(lastAddrW[0]), .last_we_o(lastWeW[0])
  );

  sap_bus_error_responder #(.RESP_LAT(LAT1), .ERR_PATTERN(PAT), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gntW[1]), .rvalid_o(rvalidW[1]), .rdata_o(rdataW[1]),
    .err_o(errW[1]), .clear_i(clear), .err_count_o(cnt1), .err_irq_o(irqW[1]),
    .last_addr_o(lastAddrW[1]), .last_we_o(lastWeW[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic applyStimulus(input bit doChk, input bit r, input bit w, input bit c,
                               input bit rs, input logic [31:0] a);
    bit g;
    bit wasResp;
    logic [31:0] cntObs;
    @(negedge clk);
    req   = r;
    we    = w;
    clear = c;
    rst   = rs;
    addr  = a;
    be    = 4'($urandom);
    wdata = $urandom;
    #1;
    for (int i = 0; i < 2; i++) begin
      g       = r && (cyc >= nextFree[i]);
      wasResp = (cyc == respAt[i]);
      if (doChk) begin
        cntObs = (i == 0) ? {28'b0, cnt0} : {16'b0, cnt1};
        checkOutput($sformatf("dut%0d gnt", i), {31'b0, gntW[i]}, {31'b0, g});
        checkOutput($sformatf("dut%0d rvalid", i), {31'b0, rvalidW[i]}, {31'b0, wasResp});
        checkOutput($sformatf("dut%0d err", i), {31'b0, errW[i]}, {31'b0, wasResp});
        checkOutput($sformatf("dut%0d rdata", i), rdataW[i], wasResp ? PAT : 32'h0);
        checkOutput($sformatf("dut%0d count", i), cntObs, 32'(mCount[i]));
        checkOutput($sformatf("dut%0d irq", i), {31'b0, irqW[i]}, {31'b0, mIrq[i]});
        checkOutput($sformatf("dut%0d last_addr", i), lastAddrW[i], mAddr[i]);
        checkOutput($sformatf("dut%0d last_we", i), {31'b0, lastWeW[i]}, {31'b0, mWe[i]});
      end
      if (rs) begin
        nextFree[i] = cyc + 1;
        respAt[i]   = -1;
        mCount[i]   = 0;
        mIrq[i]     = 0;
        mAddr[i]    = '0;
        mWe[i]      = 0;
      end else begin
        if (g) begin
          respAt[i]   = cyc + lat[i];
          nextFree[i] = cyc + lat[i] + 1;
`ifdef SAP_BUS_ERR_LOG_EN
          mAddr[i] = a;
          mWe[i]   = w;
`endif
        end
        if (c) mCount[i] = g ? 1 : 0;
        else if (g && mCount[i] < cntMax[i]) mCount[i] = mCount[i] + 1;
        if (wasResp) mIrq[i] = 1;
        else if (c) mIrq[i] = 0;
      end
    end
    cyc++;
  endtask

  initial begin
    // Bring both instances out of reset
    applyStimulus(0, 0, 0, 0, 1, 32'h0);
    applyStimulus(1, 0, 0, 0, 1, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);

    // Single read of the error window
    applyStimulus(1, 1, 0, 0, 0, 32'hBADACCE5);
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 0, 0, 32'h0);

    // Request held high for eight cycles
    for (int k = 0; k < 8; k++) applyStimulus(1, 1, k[0], 0, 0, 32'h2000_0000 + 32'(k));
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 0, 0, 32'h0);

    // Logged write
    applyStimulus(1, 1, 1, 0, 0, 32'h4100_0004);
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 0, 0, 32'h0);

    // Clear coinciding with the RESP cycle of the short-latency instance, then a later clear
    applyStimulus(1, 1, 0, 0, 0, 32'hDEAD_0000);
    applyStimulus(1, 0, 0, 1, 0, 32'h0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 1, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);

    // Reset pulse while the long-latency instance waits; a new request right after
    applyStimulus(1, 1, 1, 0, 0, 32'h1234_5678);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 1, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 32'h5555_0000);
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 0, 0, 32'h0);

    // Saturate the 4-bit counter, then clear together with a grant
    for (int k = 0; k < 40; k++) applyStimulus(1, 1, 0, 0, 0, 32'h6000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) begin
      if (cyc >= nextFree[0]) begin
        applyStimulus(1, 1, 0, 1, 0, 32'h7000_0000);
        break;
      end
      applyStimulus(1, 1, 0, 0, 0, 32'h7000_0001);
    end
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 0, 32'h0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
